// File: rtl/plot_sink_framebuffer.sv
// Plot-command sink: buffers {x,y,colour} in a small FIFO, drains into a WIDTHxHEIGHT frame memory,
// serves a 1-cycle scan-out read port and full-screen clears. Define PLOT_SINK_XOR_EN for XOR drawing.
module plot_sink_framebuffer #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int COLOUR_W   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                plot,
  input  logic [7:0]          RX,
  input  logic [6:0]          RY,
  input  logic [COLOUR_W-1:0] colour,
  output logic                busy,
  input  logic                clear,
  input  logic                rd_req,
  input  logic [7:0]          rd_x,
  input  logic [6:0]          rd_y,
  output logic [COLOUR_W-1:0] rd_colour,
  output logic                rd_valid,
  output logic [7:0]          drop_count
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam logic [14:0] NPIX15 = 15'(NPIX);
  localparam logic [PW:0] FULL   = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return 15'(y) * 15'(WIDTH) + 15'(x);
  endfunction

  function automatic logic in_range(input logic [7:0] x, input logic [6:0] y);
    return ({1'b0, x} < 9'(WIDTH)) && ({1'b0, y} < 8'(HEIGHT));
  endfunction

  logic [COLOUR_W-1:0] r_mem [NPIX];

  logic [7:0]          r_fx [FIFO_DEPTH];
  logic [6:0]          r_fy [FIFO_DEPTH];
  logic [COLOUR_W-1:0] r_fc [FIFO_DEPTH];
  logic [PW-1:0]       r_wptr, r_rptr;
  logic [PW:0]         r_count;

  state_t              r_state, w_next;
  logic [14:0]         r_clr_addr;

  logic                w_busy, w_start_clr, w_accept, w_push, w_drop, w_pop, w_clr_we;
  logic                w_we;
  logic [14:0]         w_waddr;
  logic [COLOUR_W-1:0] w_wdata;
  logic [7:0]          w_hx;
  logic [6:0]          w_hy;
  logic [COLOUR_W-1:0] w_hc;

  assign w_hx = r_fx[r_rptr];
  assign w_hy = r_fy[r_rptr];
  assign w_hc = r_fc[r_rptr];

  // busy depends only on registered state so a same-cycle pop cannot release it
  assign w_busy      = (r_count == FULL) || (r_state == S_CLEAR);
  assign w_start_clr = clear && (r_state != S_CLEAR);
  assign w_accept    = plot && !w_busy && !w_start_clr;
  assign w_push      = w_accept && in_range(RX, RY);
  assign w_drop      = w_accept && !in_range(RX, RY);
  assign w_clr_we    = (r_state == S_CLEAR) && !rd_req && (r_clr_addr != NPIX15);

`ifdef PLOT_SINK_XOR_EN
  logic                r_ph;
  logic [COLOUR_W-1:0] r_rmw;
  logic                w_rmw_rd;

  // phase 0 fetches the old pixel, phase 1 writes old^colour and pops
  assign w_rmw_rd = (r_state == S_DRAIN) && !rd_req && (r_count != '0) && !r_ph;
  assign w_pop    = (r_state == S_DRAIN) && !rd_req && r_ph;

  always_ff @(posedge clock) begin
    if (w_rmw_rd) r_rmw <= r_mem[pix_addr(w_hx, w_hy)];
  end

  always_ff @(posedge clock) begin
    if (reset || w_start_clr) r_ph <= 1'b0;
    else if (w_rmw_rd)        r_ph <= 1'b1;
    else if (w_pop)           r_ph <= 1'b0;
  end
`else
  assign w_pop = (r_state == S_DRAIN) && !rd_req && (r_count != '0);
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_clr)  w_next = S_CLEAR;
        else if (w_push)  w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_start_clr) w_next = S_CLEAR;
        else if (!w_push && ((r_count == '0) || (w_pop && r_count == (PW+1)'(1))))
          w_next = S_IDLE;
      end
      S_CLEAR: begin
        if (r_clr_addr == NPIX15) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // memory write port: clear has its own state, so the two sources never overlap
  always_comb begin
    busy    = w_busy;
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!reset) begin
      if (w_clr_we) begin
        w_we    = 1'b1;
        w_waddr = r_clr_addr;
      end else if (w_pop) begin
        w_we    = 1'b1;
        w_waddr = pix_addr(w_hx, w_hy);
`ifdef PLOT_SINK_XOR_EN
        w_wdata = r_rmw ^ w_hc;
`else
        w_wdata = w_hc;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fx[r_wptr] <= RX;
      r_fy[r_wptr] <= RY;
      r_fc[r_wptr] <= colour;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_clr_addr <= '0;
      drop_count <= '0;
    end else begin
      if (w_start_clr) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_clr_addr <= '0;
      end else begin
        if (w_push)   r_wptr     <= r_wptr + PW'(1);
        if (w_pop)    r_rptr     <= r_rptr + PW'(1);
        r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        if (w_clr_we) r_clr_addr <= r_clr_addr + 15'd1;
      end
      if (w_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid  <= 1'b0;
      rd_colour <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req)
        rd_colour <= in_range(rd_x, rd_y) ? r_mem[pix_addr(rd_x, rd_y)] : '0;
    end
  end

endmodule

// File: tb/tb_plot_sink_framebuffer.sv
// Scoreboard bench for plot_sink_framebuffer: reads push expected pixels from an array model,
// a negedge monitor pops and compares on rd_valid.
module tb_plot_sink_framebuffer;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset, plot, clear, rd_req;
  logic [7:0] RX, rd_x;
  logic [6:0] RY, rd_y;
  logic [1:0] colour;
  logic       busy, rd_valid;
  logic [1:0] rd_colour;
  logic [7:0] drop_count;

  always #5 clock = ~clock;

  plot_sink_framebuffer #(.WIDTH(W), .HEIGHT(H), .COLOUR_W(2), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .plot(plot), .RX(RX), .RY(RY), .colour(colour),
    .busy(busy), .clear(clear), .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_colour(rd_colour), .rd_valid(rd_valid), .drop_count(drop_count)
  );

  int model_mem [N];
  int model_drop;
  int n_vec, n_err;
  int exp_q[$];
  int xy_q[$];
  int tx[$], ty[$];

  function automatic void check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void model_plot(input int x, input int y, input int c);
    if (x < W && y < H) begin
`ifdef PLOT_SINK_XOR_EN
      model_mem[y*W+x] = model_mem[y*W+x] ^ c;
`else
      model_mem[y*W+x] = c;
`endif
    end else if (model_drop < 255) begin
      model_drop++;
    end
  endfunction

  function automatic int model_read(input int x, input int y);
    return (x < W && y < H) ? model_mem[y*W+x] : 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_plot(input int x, input int y, input int c, input bit accept);
    logic [31:0] vx, vy, vc;
    vx = x; vy = y; vc = c;
    plot = 1'b1; RX = vx[7:0]; RY = vy[6:0]; colour = vc[1:0];
    tick();
    plot = 1'b0;
    if (accept) model_plot(x, y, c);
  endtask

  task automatic do_read(input int x, input int y);
    logic [31:0] vx, vy;
    vx = x; vy = y;
    rd_req = 1'b1; rd_x = vx[7:0]; rd_y = vy[6:0];
    exp_q.push_back(model_read(x, y));
    xy_q.push_back(y * 256 + x);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic wait_not_busy(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check(nm, int'(done), 1);
    tick();
  endtask

  always @(negedge clock) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 expected no read pending");
      end else begin
        int e, xy;
        e  = exp_q.pop_front();
        xy = xy_q.pop_front();
        check($sformatf("read(%0d,%0d)", xy % 256, xy / 256), int'(rd_colour), e);
      end
    end
  end

  initial begin
    int cnt, base;
    reset = 1'b1; plot = 1'b0; clear = 1'b0; rd_req = 1'b0;
    RX = '0; RY = '0; colour = '0; rd_x = '0; rd_y = '0;
    n_vec = 0; n_err = 0; model_drop = 0;
    for (int i = 0; i < N; i++) model_mem[i] = 0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_colour", int'(rd_colour), 0);
    check("rst_drop", int'(drop_count), 0);
    reset = 1'b0;
    tick();

    // first clear; a plot offered while clearing must be ignored
    clear = 1'b1;
    tick();
    clear = 1'b0;
    plot = 1'b1; RX = 8'd7; RY = 7'd7; colour = 2'd3;
    cnt = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      if (!busy) break;
      cnt++;
      if (i == 0) begin
        @(posedge clock);
        #1;
        plot = 1'b0;
      end
    end
    check("clear_busy_cycles", cnt, 19201);
    tick();
    do_read(7, 7);
    for (int k = 0; k < 4; k++) do_read($urandom_range(0, W-1), $urandom_range(0, H-1));
    do_read(W-1, H-1);

    // single plot then read it and its neighbour
    do_plot(10, 5, 3, 1'b1);
    idle(3);
    do_read(10, 5);
    do_read(11, 5);
    idle(2);

    // back-pressure with reads holding the memory
    begin
      int xs[6];
      int cs[6];
      xs = '{20, 21, 22, 22, 24, 25};
      cs = '{1, 2, 3, 1, 3, 3};
      rd_req = 1'b1; rd_x = 8'd0; rd_y = 7'd0;
      for (int i = 0; i < 6; i++) begin
        exp_q.push_back(model_read(0, 0));
        xy_q.push_back(0);
        check($sformatf("bp_busy%0d", i), int'(busy), (i >= 4) ? 1 : 0);
        plot = 1'b1; RX = 8'(xs[i]); RY = 7'd30; colour = 2'(cs[i]);
        tick();
        if (i < 4) model_plot(xs[i], 30, cs[i]);
      end
      plot = 1'b0; rd_req = 1'b0;
      idle(12);
      check("bp_busy_released", int'(busy), 0);
      do_read(20, 30); do_read(21, 30); do_read(22, 30); do_read(24, 30); do_read(25, 30);
    end

    // randomized plots, spaced so the FIFO never fills
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 30; k++) begin
        int x, y;
        x = $urandom_range(0, 169);
        y = $urandom_range(0, 125);
        tx.push_back(x); ty.push_back(y);
        do_plot(x, y, $urandom_range(0, 3), 1'b1);
        idle(2);
      end
      idle(10);
      for (int k = 0; k < 15; k++) begin
        int j;
        j = $urandom_range(0, tx.size() - 1);
        do_read(tx[j], ty[j]);
      end
      do_read($urandom_range(W, 255), $urandom_range(0, H-1));
      check($sformatf("rand_drop%0d", r), int'(drop_count), model_drop);
    end

    // out-of-range plots
    base = model_drop;
    do_plot(160, 0, 1, 1'b1);
    do_plot(0, 120, 1, 1'b1);
    idle(4);
    check("drop_two", int'(drop_count), (base + 2 > 255) ? 255 : base + 2);
    do_read(0, 1);
    do_read(0, 0);
    for (int k = 0; k < 300; k++) begin
      if (k % 2 == 0) do_plot($urandom_range(W, 255), $urandom_range(0, 127), 2, 1'b1);
      else            do_plot($urandom_range(0, 255), $urandom_range(H, 127), 2, 1'b1);
    end
    idle(2);
    check("drop_sat", int'(drop_count), model_drop);
    check("drop_sat_255", int'(drop_count), 255);

    // plot+clear in one cycle with two entries stuck behind reads
    base = model_drop;
    rd_req = 1'b1; rd_x = 8'd1; rd_y = 7'd1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model_read(1, 1));
      xy_q.push_back(256 + 1);
      plot = 1'b1; RX = 8'(40 + i); RY = 7'd40; colour = 2'(i + 1);
      clear = (i == 2);
      tick();
    end
    plot = 1'b0; clear = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < N; i++) model_mem[i] = 0;
    wait_not_busy("clear2_done");
    do_read(40, 40); do_read(41, 40); do_read(42, 40);
    for (int k = 0; k < 10; k++) begin
      int j;
      j = $urandom_range(0, tx.size() - 1);
      do_read(tx[j], ty[j]);
    end
    check("clear2_drop", int'(drop_count), base);

    // reset in the middle of a clear
    do_plot(39, 31, 2, 1'b1);
    do_plot(80, 37, 3, 1'b1);
    idle(6);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (5000) @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
    check("midclr_rst_busy", int'(busy), 0);
    reset = 1'b0;
    for (int i = 0; i < 5000; i++) model_mem[i] = 0;
    model_drop = 0;
    check("midclr_rst_drop", int'(drop_count), 0);
    tick();
    do_read(39, 31);
    do_read(80, 37);
    do_read(40, 31);

    // repeated plots at one pixel
    do_plot(3, 3, 1, 1'b1);
    do_plot(3, 3, 1, 1'b1);
    idle(8);
    do_read(3, 3);
    do_plot(3, 3, 2, 1'b1);
    idle(8);
    do_read(3, 3);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    #1;
    check("reads_outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
